// File: rtl/rect_plotter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rect_plotter
// Summary  : Buffers box-draw requests in a small FIFO and rasterises each box
//            into one clipped VGA pixel write per clock.
// Revision : 1.0  initial release
// ============================================================================
module rect_plotter #(
    parameter int SIZE_BITS  = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int SCREEN_W   = 160,
    parameter int SCREEN_H   = 120
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_x,
    input  logic [6:0] req_y,
    input  logic [2:0] req_colour,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       rect_done,
    output logic       busy
);

    localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W   = 2 * SIZE_BITS;
    localparam int c_ENTRY_W = 18;

    localparam logic [c_PTR_W:0]   c_FULL_CNT = FIFO_DEPTH[c_PTR_W:0];
    localparam logic [c_PTR_W:0]   c_OCC_ONE  = 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = 1;
    localparam logic [c_CNT_W-1:0] c_CTR_ONE  = 1;
    localparam logic [c_CNT_W-1:0] c_CTR_MAX  = {c_CNT_W{1'b1}};
    localparam logic [8:0]         c_X_LIM    = SCREEN_W[8:0];
    localparam logic [7:0]         c_Y_LIM    = SCREEN_H[7:0];

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_DRAW = 1'b1;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [c_ENTRY_W-1:0] r_fifo [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_last;
    logic [c_ENTRY_W-1:0] w_head;

    logic [0:0]           r_state;
    logic [c_CNT_W-1:0]   r_counter;
    logic [7:0]           r_base_x;
    logic [6:0]           r_base_y;
    logic [2:0]           r_base_col;
    logic                 r_out_valid;

    assign w_full  = (r_count == c_FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_last  = (r_state == c_DRAW) && (r_counter == c_CTR_MAX);
    // Full is judged on current occupancy, so a same-cycle pop never frees a slot.
    assign w_push  = req_valid && !w_full;
    assign w_pop   = !w_empty && ((r_state == c_IDLE) || w_last);
    assign w_head  = r_fifo[r_rd_ptr];

    assign req_ready = !w_full;
    assign busy      = !w_empty || (r_state == c_DRAW) || r_out_valid;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {req_x, req_y, req_colour};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_OCC_ONE;
                2'b01:   r_count <= r_count - c_OCC_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Box sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= c_IDLE;
            r_counter  <= '0;
            r_base_x   <= '0;
            r_base_y   <= '0;
            r_base_col <= '0;
        end else begin
            if (w_pop) begin
                r_base_x   <= w_head[17:10];
                r_base_y   <= w_head[9:3];
                r_base_col <= w_head[2:0];
            end
            case (r_state)
                c_IDLE: begin
                    r_counter <= '0;
                    if (!w_empty) begin
                        r_state <= c_DRAW;
                    end
                end
                c_DRAW: begin
                    if (w_last) begin
                        r_counter <= '0;
                        if (w_empty) begin
                            r_state <= c_IDLE;
                        end
                    end else begin
                        r_counter <= r_counter + c_CTR_ONE;
                    end
                end
                default: begin
                    r_state   <= c_IDLE;
                    r_counter <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pixel output register
    // ------------------------------------------------------------------
    logic [SIZE_BITS-1:0] w_dx;
    logic [SIZE_BITS-1:0] w_dy;
    logic [8:0]           w_xs;
    logic [7:0]           w_ys;

    assign w_dx = r_counter[SIZE_BITS-1:0];
    assign w_dy = r_counter[c_CNT_W-1:SIZE_BITS];
    // One extra bit keeps boxes that run off the right/bottom edge from wrapping back on-screen.
    assign w_xs = {1'b0, r_base_x} + {{(9 - SIZE_BITS){1'b0}}, w_dx};
    assign w_ys = {1'b0, r_base_y} + {{(8 - SIZE_BITS){1'b0}}, w_dy};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x           <= '0;
            y           <= '0;
            colour      <= '0;
            plot        <= 1'b0;
            rect_done   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (r_state == c_DRAW) begin
            x           <= w_xs[7:0];
            y           <= w_ys[6:0];
            colour      <= r_base_col;
            plot        <= (w_xs < c_X_LIM) && (w_ys < c_Y_LIM);
            rect_done   <= (r_counter == c_CTR_MAX);
            r_out_valid <= 1'b1;
        end else begin
            plot        <= 1'b0;
            rect_done   <= 1'b0;
            r_out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rect_plotter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rect_plotter
// Summary  : Directed bench for rect_plotter with hand-computed pixel expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_rect_plotter;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       req_valid = 1'b0;
    logic [7:0] req_x = '0;
    logic [6:0] req_y = '0;
    logic [2:0] req_colour = '0;
    logic       req_ready;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       rect_done;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rq_x [4];
    logic [6:0] rq_y [4];
    logic [2:0] rq_c [4];

    always #5 clock = ~clock;

    rect_plotter dut (
        .clock      (clock),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .rect_done  (rect_done),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected pixel i (0..255 within a box) of a box at (bx,by).
    function automatic bit pix_bad(input logic [7:0] bx, input logic [6:0] by,
                                   input logic [2:0] bc, input int i);
        logic [8:0] xs;
        logic [7:0] ys;
        logic       ep;
        xs = {1'b0, bx} + 9'(i % 16);
        ys = {1'b0, by} + 8'((i / 16) % 16);
        ep = (xs < 9'd160) && (ys < 8'd120);
        return (x !== xs[7:0]) || (y !== ys[6:0]) || (colour !== bc) ||
               (plot !== ep) || (rect_done !== ((i % 256) == 255));
    endfunction

    task automatic push(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
        int guard = 0;
        req_valid  = 1'b1;
        req_x      = px;
        req_y      = py;
        req_colour = pc;
        while (!req_ready && guard < 2000) begin
            @(negedge clock);
            guard++;
        end
        check("push_wait", 32'(guard < 2000), 1);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic run_box(input string tag, input logic [7:0] bx, input logic [6:0] by,
                           input logic [2:0] bc, input int exp_plots);
        int errs = 0;
        int plots = 0;
        int dones = 0;
        int viol = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clock);
            if (pix_bad(bx, by, bc, i)) errs++;
            if (plot) plots++;
            if (rect_done) dones++;
            if (plot && (x >= 8'd160 || y >= 7'd120)) viol++;
        end
        check({tag, "_pix_errs"}, errs, 0);
        check({tag, "_plots"}, plots, exp_plots);
        check({tag, "_dones"}, dones, 1);
        check({tag, "_clip_viol"}, viol, 0);
    endtask

    // Four back-to-back requests with req_valid held; the FIFO fills while box #1 draws.
    task automatic stream4(input string tag);
        int errs = 0;
        int rdy_errs = 0;
        int dones = 0;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    int guard = 0;
                    req_valid  = 1'b1;
                    req_x      = rq_x[k];
                    req_y      = rq_y[k];
                    req_colour = rq_c[k];
                    while (!req_ready && guard < 3000) begin
                        @(negedge clock);
                        guard++;
                    end
                    check({tag, "_accept_wait"}, 32'(guard < 3000), 1);
                    @(posedge clock);
                    @(negedge clock);
                end
                req_valid = 1'b0;
            end
            begin
                logic exp_rdy;
                @(negedge clock);
                @(negedge clock);
                check({tag, "_pre_plot"}, plot, 0);
                for (int i = 0; i < 1024; i++) begin
                    @(negedge clock);
                    if (pix_bad(rq_x[i / 256], rq_y[i / 256], rq_c[i / 256], i)) errs++;
                    exp_rdy = (i == 255) || (i >= 511);
                    if (req_ready !== exp_rdy) rdy_errs++;
                    if (rect_done) dones++;
                end
            end
        join
        check({tag, "_pix_errs"}, errs, 0);
        check({tag, "_ready_errs"}, rdy_errs, 0);
        check({tag, "_dones"}, dones, 4);
        @(negedge clock);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_plot_after"}, plot, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int plots;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_colour", colour, 0);
        check("rst_plot", plot, 0);
        check("rst_done", rect_done, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 1);
        resetn = 1'b1;
        @(negedge clock);

        // 1: on-screen box, latency and completion
        push(8'd20, 7'd60, 3'b100);
        @(negedge clock);
        check("t1_lat_plot", plot, 0);
        check("t1_lat_busy", busy, 1);
        run_box("t1", 8'd20, 7'd60, 3'b100, 256);
        @(negedge clock);
        check("t1_end_plot", plot, 0);
        check("t1_end_done", rect_done, 0);
        check("t1_end_busy", busy, 0);

        // 2: partially clipped box, 10 x 10 visible pixels
        push(8'd150, 7'd110, 3'b001);
        @(negedge clock);
        run_box("t2", 8'd150, 7'd110, 3'b001, 100);
        @(negedge clock);
        check("t2_end_busy", busy, 0);

        // 3: fully off-screen box
        push(8'd160, 7'd104, 3'b001);
        @(negedge clock);
        run_box("t3", 8'd160, 7'd104, 3'b001, 0);
        @(negedge clock);
        check("t3_end_busy", busy, 0);

        // 4: four requests streamed with valid held high
        rq_x[0] = 8'd0;   rq_y[0] = 7'd0;   rq_c[0] = 3'b001;
        rq_x[1] = 8'd40;  rq_y[1] = 7'd10;  rq_c[1] = 3'b010;
        rq_x[2] = 8'd80;  rq_y[2] = 7'd50;  rq_c[2] = 3'b011;
        rq_x[3] = 8'd120; rq_y[3] = 7'd90;  rq_c[3] = 3'b111;
        stream4("t4");

        // 5: full FIFO with a pop on the same edge, mixed clipping and the erase colour
        rq_x[0] = 8'd5;   rq_y[0] = 7'd5;   rq_c[0] = 3'b000;
        rq_x[1] = 8'd152; rq_y[1] = 7'd0;   rq_c[1] = 3'b110;
        rq_x[2] = 8'd100; rq_y[2] = 7'd112; rq_c[2] = 3'b010;
        rq_x[3] = 8'd250; rq_y[3] = 7'd20;  rq_c[3] = 3'b101;
        stream4("t5");

        // 6: asynchronous reset mid-box with one request queued
        push(8'd30, 7'd20, 3'b010);
        push(8'd40, 7'd30, 3'b011);
        repeat (101) @(negedge clock);
        check("t6_mid_plot", plot, 1);
        check("t6_mid_x", x, 34);
        check("t6_mid_y", y, 26);
        resetn = 1'b0;
        #1;
        check("t6_rst_plot", plot, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ready", req_ready, 1);
        check("t6_rst_x", x, 0);
        @(negedge clock);
        resetn = 1'b1;
        plots = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (plot) plots++;
        end
        check("t6_no_pixels", plots, 0);
        check("t6_busy", busy, 0);
        check("t6_ready", req_ready, 1);

        // 7: normal operation resumes after the reset
        push(8'd0, 7'd104, 3'b101);
        @(negedge clock);
        run_box("t7", 8'd0, 7'd104, 3'b101, 256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
